// File: rtl/multi_debounce_pulse.sv
// Per-channel button conditioner: 2-flop synchroniser, stability filter and edge pulse generator.
// Defining DBN_EVENT_CNT_EN adds cnt_clr / event_cnt with saturating per-channel edge counters.
module multi_debounce_pulse #(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_PERIOD = 5,
   parameter int PULSE_PER       = 1,
   parameter int EDGE_MODE       = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [CHANNELS-1:0]   button,
`ifdef DBN_EVENT_CNT_EN
   input  logic                  cnt_clr,
   output logic [CHANNELS*8-1:0] event_cnt,
`endif
   output logic [CHANNELS-1:0]   level,
   output logic [CHANNELS-1:0]   result
);

   localparam int DW = $clog2(DEBOUNCE_PERIOD + 1);
   localparam int PW = $clog2(PULSE_PER + 1);

   localparam logic [DW-1:0] DCNT_ZERO  = DW'(1'b0);
   localparam logic [DW-1:0] DCNT_ONE   = DW'(1'b1);
   localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_PERIOD - 1);
   localparam logic [PW-1:0] PCNT_ZERO  = PW'(1'b0);
   localparam logic [PW-1:0] PCNT_ONE   = PW'(1'b1);
   localparam logic [PW-1:0] PCNT_LAST  = PW'(PULSE_PER);
   localparam logic [1:0]    EMODE      = 2'(EDGE_MODE);

   typedef enum logic {
      IDLE  = 1'b0,
      PULSE = 1'b1
   } pulse_state_t;

`ifdef DBN_EVENT_CNT_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] next_value;
      if (value == 8'hFF) begin
         next_value = value;
      end else begin
         next_value = value + 8'd1;
      end
      return next_value;
   endfunction
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic          meta_r;
      logic          sync_r;
      logic          level_r;
      logic          level_s;
      logic [DW-1:0] dcnt_r;
      logic [DW-1:0] dcnt_s;
      logic          accept_s;
      logic          qual_s;
      pulse_state_t  state_r;
      pulse_state_t  state_s;
      logic [PW-1:0] pcnt_r;
      logic [PW-1:0] pcnt_s;

      // Stability filter: level follows sync only after DEBOUNCE_PERIOD unbroken cycles of difference.
      always_comb begin
         level_s  = level_r;
         dcnt_s   = DCNT_ZERO;
         accept_s = 1'b0;
         if (sync_r != level_r) begin
            if (dcnt_r == DCNT_LAST) begin
               accept_s = 1'b1;
               level_s  = sync_r;
               dcnt_s   = DCNT_ZERO;
            end else begin
               dcnt_s   = dcnt_r + DCNT_ONE;
            end
         end else begin
            dcnt_s = DCNT_ZERO;
         end
      end

      // Edge qualification; sync holds the newly accepted level value at acceptance.
      always_comb begin
         qual_s = 1'b0;
         case (EMODE)
            2'd0:    qual_s = accept_s & sync_r;
            2'd1:    qual_s = accept_s & ~sync_r;
            2'd2:    qual_s = accept_s;
            default: qual_s = accept_s & sync_r;
         endcase
      end

      // Pulse machine next state; a qualifying edge while pulsing restarts the count.
      always_comb begin
         state_s = state_r;
         pcnt_s  = pcnt_r;
         case (state_r)
            IDLE: begin
               if (qual_s) begin
                  state_s = PULSE;
                  pcnt_s  = PCNT_ONE;
               end else begin
                  state_s = IDLE;
                  pcnt_s  = PCNT_ZERO;
               end
            end
            PULSE: begin
               if (qual_s) begin
                  state_s = PULSE;
                  pcnt_s  = PCNT_ONE;
               end else if (pcnt_r == PCNT_LAST) begin
                  state_s = IDLE;
                  pcnt_s  = PCNT_ZERO;
               end else begin
                  state_s = PULSE;
                  pcnt_s  = pcnt_r + PCNT_ONE;
               end
            end
            default: begin
               state_s = IDLE;
               pcnt_s  = PCNT_ZERO;
            end
         endcase
      end

      // Channel state registers: synchroniser, filter and pulse machine.
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            meta_r  <= 1'b0;
            sync_r  <= 1'b0;
            level_r <= 1'b0;
            dcnt_r  <= DCNT_ZERO;
            state_r <= IDLE;
            pcnt_r  <= PCNT_ZERO;
         end else begin
            meta_r  <= button[i];
            sync_r  <= meta_r;
            level_r <= level_s;
            dcnt_r  <= dcnt_s;
            state_r <= state_s;
            pcnt_r  <= pcnt_s;
         end
      end

      assign level[i]  = level_r;
      assign result[i] = (state_r == PULSE);

`ifdef DBN_EVENT_CNT_EN
      logic [7:0] ecnt_r;
      logic [7:0] ecnt_s;

      // Event counter next value; clear wins over a simultaneous edge.
      always_comb begin
         ecnt_s = ecnt_r;
         if (cnt_clr) begin
            ecnt_s = 8'd0;
         end else if (qual_s) begin
            ecnt_s = sat_inc8(ecnt_r);
         end else begin
            ecnt_s = ecnt_r;
         end
      end

      // Event counter register.
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            ecnt_r <= 8'd0;
         end else begin
            ecnt_r <= ecnt_s;
         end
      end

      assign event_cnt[8*i +: 8] = ecnt_r;
`endif
   end

endmodule

// File: tb/tb_multi_debounce_pulse.sv
// Self-checking bench for multi_debounce_pulse: four instances cover edge modes and pulse widths.
module tb_multi_debounce_pulse;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic [3:0] b0, b1, b2, b3;
   logic [3:0] lvl0, lvl1, lvl2, lvl3;
   logic [3:0] res0, res1, res2, res3;
`ifdef DBN_EVENT_CNT_EN
   logic        cnt_clr;
   logic [31:0] ecnt0, ecnt1, ecnt2, ecnt3;
`endif

   multi_debounce_pulse #(.CHANNELS(4), .DEBOUNCE_PERIOD(5), .PULSE_PER(3), .EDGE_MODE(0)) u0 (
      .clk(clk), .reset_n(reset_n), .button(b0),
`ifdef DBN_EVENT_CNT_EN
      .cnt_clr(cnt_clr), .event_cnt(ecnt0),
`endif
      .level(lvl0), .result(res0));

   multi_debounce_pulse #(.CHANNELS(4), .DEBOUNCE_PERIOD(5), .PULSE_PER(3), .EDGE_MODE(1)) u1 (
      .clk(clk), .reset_n(reset_n), .button(b1),
`ifdef DBN_EVENT_CNT_EN
      .cnt_clr(cnt_clr), .event_cnt(ecnt1),
`endif
      .level(lvl1), .result(res1));

   multi_debounce_pulse #(.CHANNELS(4), .DEBOUNCE_PERIOD(5), .PULSE_PER(3), .EDGE_MODE(2)) u2 (
      .clk(clk), .reset_n(reset_n), .button(b2),
`ifdef DBN_EVENT_CNT_EN
      .cnt_clr(cnt_clr), .event_cnt(ecnt2),
`endif
      .level(lvl2), .result(res2));

   multi_debounce_pulse #(.CHANNELS(4), .DEBOUNCE_PERIOD(5), .PULSE_PER(10), .EDGE_MODE(2)) u3 (
      .clk(clk), .reset_n(reset_n), .button(b3),
`ifdef DBN_EVENT_CNT_EN
      .cnt_clr(cnt_clr), .event_cnt(ecnt3),
`endif
      .level(lvl3), .result(res3));

   typedef struct {
      int         dut;
      logic [3:0] lvl;
      logic [3:0] res;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [3:0] obs_lvl(input int d);
      case (d)
         0:       return lvl0;
         1:       return lvl1;
         2:       return lvl2;
         default: return lvl3;
      endcase
   endfunction

   function automatic logic [3:0] obs_res(input int d);
      case (d)
         0:       return res0;
         1:       return res1;
         2:       return res2;
         default: return res3;
      endcase
   endfunction

   task automatic push_exp(input int d, input logic [3:0] l, input logic [3:0] r);
      exp_t e;
      e.dut = d;
      e.lvl = l;
      e.res = r;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      b0 = 4'hF;
      b1 = 4'h0;
      b2 = 4'h0;
      b3 = 4'h0;
`ifdef DBN_EVENT_CNT_EN
      cnt_clr = 1'b0;
`endif
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (lvl0 !== 4'h0) begin n_fail++; $display("FAIL reset level0: got %b expected 0000", lvl0); end
         n_checks++;
         if (res0 !== 4'h0) begin n_fail++; $display("FAIL reset result0: got %b expected 0000", res0); end
         n_checks++;
         if (res3 !== 4'h0) begin n_fail++; $display("FAIL reset result3: got %b expected 0000", res3); end
`ifdef DBN_EVENT_CNT_EN
         n_checks++;
         if (ecnt0 !== 32'h0) begin n_fail++; $display("FAIL reset event_cnt: got %h expected 0", ecnt0); end
`endif
      end
   endtask

   // Inputs held high through reset release: all channels rise together, then fall together.
   task automatic test_parallel();
      exp_t e;
      for (int k = 1; k <= 24; k++)
         push_exp(0, (k >= 7 && k < 19) ? 4'hF : 4'h0, (k >= 7 && k <= 9) ? 4'hF : 4'h0);
      reset_n = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         if (k == 13) b0 = 4'h0;
         tick();
         e = exp_q.pop_front();
         n_checks++;
         if (obs_lvl(e.dut) !== e.lvl) begin n_fail++; $display("FAIL parallel level dut%0d edge %0d: got %b expected %b", e.dut, k, obs_lvl(e.dut), e.lvl); end
         n_checks++;
         if (obs_res(e.dut) !== e.res) begin n_fail++; $display("FAIL parallel result dut%0d edge %0d: got %b expected %b", e.dut, k, obs_res(e.dut), e.res); end
      end
`ifdef DBN_EVENT_CNT_EN
      n_checks++;
      if (ecnt0 !== 32'h01010101) begin n_fail++; $display("FAIL parallel event_cnt: got %h expected 01010101", ecnt0); end
`endif
   endtask

   task automatic test_clean_step();
      exp_t e;
      for (int k = 1; k <= 24; k++)
         push_exp(0, (k >= 7 && k < 19) ? 4'h1 : 4'h0, (k >= 7 && k <= 9) ? 4'h1 : 4'h0);
      b0 = 4'h1;
      for (int k = 1; k <= 24; k++) begin
         if (k == 13) b0 = 4'h0;
         tick();
         e = exp_q.pop_front();
         n_checks++;
         if (obs_lvl(e.dut) !== e.lvl) begin n_fail++; $display("FAIL clean_step level edge %0d: got %b expected %b", k, obs_lvl(e.dut), e.lvl); end
         n_checks++;
         if (obs_res(e.dut) !== e.res) begin n_fail++; $display("FAIL clean_step result edge %0d: got %b expected %b", k, obs_res(e.dut), e.res); end
      end
   endtask

   // Channel 1 bounces in 2-cycle phases, settles high at cycle 8, released at cycle 20.
   task automatic test_bounce();
      exp_t e;
      int   c;
      for (int k = 1; k <= 32; k++)
         push_exp(0, (k >= 15 && k < 27) ? 4'h2 : 4'h0, (k >= 15 && k <= 17) ? 4'h2 : 4'h0);
      for (int k = 1; k <= 32; k++) begin
         c = k - 1;
         if (c < 8) b0 = (((c / 2) % 2) == 0) ? 4'h2 : 4'h0;
         else       b0 = (c < 20) ? 4'h2 : 4'h0;
         tick();
         e = exp_q.pop_front();
         n_checks++;
         if (obs_lvl(e.dut) !== e.lvl) begin n_fail++; $display("FAIL bounce level edge %0d: got %b expected %b", k, obs_lvl(e.dut), e.lvl); end
         n_checks++;
         if (obs_res(e.dut) !== e.res) begin n_fail++; $display("FAIL bounce result edge %0d: got %b expected %b", k, obs_res(e.dut), e.res); end
      end
   endtask

   task automatic test_edge_modes();
      exp_t e;
      logic [3:0] l;
      for (int k = 1; k <= 24; k++) begin
         l = (k >= 7 && k < 19) ? 4'h1 : 4'h0;
         push_exp(1, l, (k >= 19 && k <= 21) ? 4'h1 : 4'h0);
         push_exp(2, l, ((k >= 7 && k <= 9) || (k >= 19 && k <= 21)) ? 4'h1 : 4'h0);
      end
      b1 = 4'h1;
      b2 = 4'h1;
      for (int k = 1; k <= 24; k++) begin
         if (k == 13) begin b1 = 4'h0; b2 = 4'h0; end
         tick();
         for (int j = 0; j < 2; j++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_lvl(e.dut) !== e.lvl) begin n_fail++; $display("FAIL edge_modes level dut%0d edge %0d: got %b expected %b", e.dut, k, obs_lvl(e.dut), e.lvl); end
            n_checks++;
            if (obs_res(e.dut) !== e.res) begin n_fail++; $display("FAIL edge_modes result dut%0d edge %0d: got %b expected %b", e.dut, k, obs_res(e.dut), e.res); end
         end
      end
   endtask

   // Fall accepted at edge 12 while the 10-cycle rise pulse is active: one pulse through edge 21.
   task automatic test_retrigger();
      exp_t e;
      for (int k = 1; k <= 26; k++)
         push_exp(3, (k >= 7 && k < 12) ? 4'h1 : 4'h0, (k >= 7 && k <= 21) ? 4'h1 : 4'h0);
      for (int k = 1; k <= 26; k++) begin
         b3 = (k - 1 < 5) ? 4'h1 : 4'h0;
         tick();
         e = exp_q.pop_front();
         n_checks++;
         if (obs_lvl(e.dut) !== e.lvl) begin n_fail++; $display("FAIL retrigger level edge %0d: got %b expected %b", k, obs_lvl(e.dut), e.lvl); end
         n_checks++;
         if (obs_res(e.dut) !== e.res) begin n_fail++; $display("FAIL retrigger result edge %0d: got %b expected %b", k, obs_res(e.dut), e.res); end
      end
   endtask

   task automatic test_reset_mid_pulse();
      exp_t e;
      for (int k = 1; k <= 20; k++)
         push_exp(0, (k == 7 || k == 8) ? 4'h1 : 4'h0, (k == 7 || k == 8) ? 4'h1 : 4'h0);
      b0 = 4'h1;
      for (int k = 1; k <= 20; k++) begin
         if (k == 9) begin reset_n = 1'b0; b0 = 4'h0; end
         if (k == 10) reset_n = 1'b1;
         tick();
         e = exp_q.pop_front();
         n_checks++;
         if (obs_lvl(e.dut) !== e.lvl) begin n_fail++; $display("FAIL reset_mid_pulse level edge %0d: got %b expected %b", k, obs_lvl(e.dut), e.lvl); end
         n_checks++;
         if (obs_res(e.dut) !== e.res) begin n_fail++; $display("FAIL reset_mid_pulse result edge %0d: got %b expected %b", k, obs_res(e.dut), e.res); end
      end
`ifdef DBN_EVENT_CNT_EN
      n_checks++;
      if (ecnt0 !== 32'h0) begin n_fail++; $display("FAIL reset_mid_pulse event_cnt: got %h expected 0", ecnt0); end
`endif
   endtask

`ifdef DBN_EVENT_CNT_EN
   // Channel 2 toggles every 8 cycles: 300 rises, then the counter is cleared.
   task automatic test_event_cnt();
      logic [31:0] exp_q_cnt[$];
      logic [31:0] x;
      exp_q_cnt.push_back(32'h000A0000);
      exp_q_cnt.push_back(32'h00FF0000);
      exp_q_cnt.push_back(32'h00000000);
      for (int c = 0; c < 4820; c++) begin
         b0 = (c < 4800 && ((c / 8) % 2) == 0) ? 4'h4 : 4'h0;
         tick();
         if (c == 159) begin
            x = exp_q_cnt.pop_front();
            n_checks++;
            if (ecnt0 !== x) begin n_fail++; $display("FAIL event_cnt after 10 rises: got %h expected %h", ecnt0, x); end
         end
      end
      x = exp_q_cnt.pop_front();
      n_checks++;
      if (ecnt0 !== x) begin n_fail++; $display("FAIL event_cnt saturate: got %h expected %h", ecnt0, x); end
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      x = exp_q_cnt.pop_front();
      n_checks++;
      if (ecnt0 !== x) begin n_fail++; $display("FAIL event_cnt clear: got %h expected %h", ecnt0, x); end
   endtask
`endif

   initial begin
      test_reset();
      test_parallel();
      test_clean_step();
      test_bounce();
      test_edge_modes();
      test_retrigger();
      test_reset_mid_pulse();
`ifdef DBN_EVENT_CNT_EN
      test_event_cnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
